// File: rtl/vga_timing_monitor.sv
`default_nettype none
// ============================================================================
// vga_timing_monitor : measures hsync/vsync timing and reports timing lock.
// Revision 1.0 - initial release
// ============================================================================
module vga_timing_monitor #(
  parameter int CW          = 16,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vga_hs,
  input  logic          vga_vs,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_sync,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_sync,
  output logic          frame_valid,
  output logic          locked,
  output logic [CW-1:0] frame_count
);

  localparam int              c_mw      = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0]   c_sat     = '1;
  localparam logic [CW-1:0]   c_one     = CW'(1);
  localparam logic [CW-1:0]   c_pre_sat = c_sat - c_one;
  localparam logic [c_mw-1:0] c_lock    = c_mw'(LOCK_FRAMES);
  localparam logic [c_mw-1:0] c_m_one   = c_mw'(1);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_MEASURE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  // [1:0] synchronizer (already polarity-normalised), [2] previous sample
  logic [2:0]      r_hs_sync, r_vs_sync;
  logic [CW-1:0]   r_hcnt, r_hwcnt, r_vcnt, r_vwcnt;
  logic [CW-1:0]   r_h_meas, r_hsw_meas, r_vsw_meas;
  state_t          r_state, w_state_nxt;
  logic [c_mw-1:0] r_match, w_match_nxt;
  logic            w_locked_nxt, w_publish, w_fc_inc;

  logic w_hs_a, w_vs_a, w_hs_lead, w_hs_trail, w_vs_lead, w_vs_trail, w_timeout, w_same;
  logic [4*CW-1:0] w_tuple;

  assign w_hs_a     = r_hs_sync[1];
  assign w_vs_a     = r_vs_sync[1];
  assign w_hs_lead  =  r_hs_sync[1] & ~r_hs_sync[2];
  assign w_hs_trail = ~r_hs_sync[1] &  r_hs_sync[2];
  assign w_vs_lead  =  r_vs_sync[1] & ~r_vs_sync[2];
  assign w_vs_trail = ~r_vs_sync[1] &  r_vs_sync[2];
  // One-shot: fires on the clock where hcnt steps onto its saturation value
  assign w_timeout  = ~w_hs_lead & (r_hcnt == c_pre_sat);
  // Line count is taken live so the frame that just closed is reported
  assign w_tuple    = {r_h_meas, r_hsw_meas, r_vcnt, r_vsw_meas};
  assign w_same     = (w_tuple == {h_total, h_sync, v_total, v_sync});

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == c_sat) ? v : v + c_one;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_sync  <= '0;
      r_vs_sync  <= '0;
      r_hcnt     <= '0;
      r_hwcnt    <= '0;
      r_vcnt     <= '0;
      r_vwcnt    <= '0;
      r_h_meas   <= '0;
      r_hsw_meas <= '0;
      r_vsw_meas <= '0;
    end else begin
      r_hs_sync <= {r_hs_sync[1:0], vga_hs ~^ HS_POL};
      r_vs_sync <= {r_vs_sync[1:0], vga_vs ~^ VS_POL};

      if (w_hs_lead) begin
        r_hcnt   <= c_one;
        r_h_meas <= r_hcnt;
        r_hwcnt  <= c_one;
      end else begin
        r_hcnt <= sat_inc(r_hcnt);
        if (w_hs_a) r_hwcnt <= sat_inc(r_hwcnt);
      end
      if (w_hs_trail) r_hsw_meas <= r_hwcnt;

      // A coincident hsync edge belongs to the frame that is starting
      if (w_vs_lead) begin
        r_vcnt  <= w_hs_lead ? c_one : '0;
        r_vwcnt <= w_hs_lead ? c_one : '0;
      end else if (w_hs_lead) begin
        r_vcnt <= sat_inc(r_vcnt);
        if (w_vs_a) r_vwcnt <= sat_inc(r_vwcnt);
      end
      if (w_vs_trail) r_vsw_meas <= r_vwcnt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_match_nxt  = r_match;
    w_locked_nxt = locked;
    w_publish    = 1'b0;
    w_fc_inc     = 1'b0;
    if (w_timeout) begin
      w_state_nxt  = S_SEARCH;
      w_match_nxt  = '0;
      w_locked_nxt = 1'b0;
    end else if (w_vs_lead) begin
      case (r_state)
        S_SEARCH: begin
          w_state_nxt = S_MEASURE;
          w_match_nxt = '0;
        end
        S_MEASURE: begin
          w_publish   = 1'b1;
          w_match_nxt = ((r_match == '0) || w_same) ? r_match + c_m_one : c_m_one;
          if (w_match_nxt == c_lock) begin
            w_state_nxt  = S_LOCKED;
            w_locked_nxt = 1'b1;
          end
        end
        S_LOCKED: begin
          w_publish = 1'b1;
          if (w_same) begin
            w_fc_inc = 1'b1;
          end else begin
            w_state_nxt  = S_MEASURE;
            w_locked_nxt = 1'b0;
            w_match_nxt  = c_m_one;
          end
        end
        default: begin
          w_state_nxt  = S_SEARCH;
          w_match_nxt  = '0;
          w_locked_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_SEARCH;
      r_match     <= '0;
      h_total     <= '0;
      h_sync      <= '0;
      v_total     <= '0;
      v_sync      <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      frame_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_match     <= w_match_nxt;
      frame_valid <= w_publish;
      locked      <= w_locked_nxt;
      if (w_publish) {h_total, h_sync, v_total, v_sync} <= w_tuple;
      if (w_fc_inc) frame_count <= frame_count + c_one;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_monitor.sv
`default_nettype none
// tb_vga_timing_monitor : drives whole VGA frames into three monitor instances and
// checks them against a frame-level run-length lock model.
module tb_vga_timing_monitor;

  localparam int LOCK = 2;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] hw;
    logic [15:0] v;
    logic [15:0] vw;
    logic [15:0] fc;
    logic        lk;
  } rec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic hs_pin = 1'b1;
  logic vs_pin = 1'b1;
  logic hs_inv, vs_inv;
  assign hs_inv = ~hs_pin;
  assign vs_inv = ~vs_pin;

  always #5 clk = ~clk;

  logic [15:0] h0, s0, v0, w0, fc0, h1, s1, v1, w1, fc1;
  logic [11:0] h2, s2, v2, w2, fc2;
  logic        fv0, lk0, fv1, lk1, fv2, lk2;

  vga_timing_monitor #(.CW(16), .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(LOCK)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .vga_hs(hs_pin), .vga_vs(vs_pin),
    .h_total(h0), .h_sync(s0), .v_total(v0), .v_sync(w0),
    .frame_valid(fv0), .locked(lk0), .frame_count(fc0));

  vga_timing_monitor #(.CW(16), .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(LOCK)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .vga_hs(hs_inv), .vga_vs(vs_inv),
    .h_total(h1), .h_sync(s1), .v_total(v1), .v_sync(w1),
    .frame_valid(fv1), .locked(lk1), .frame_count(fc1));

  vga_timing_monitor #(.CW(12), .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(LOCK)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .vga_hs(hs_pin), .vga_vs(vs_pin),
    .h_total(h2), .h_sync(s2), .v_total(v2), .v_sync(w2),
    .frame_valid(fv2), .locked(lk2), .frame_count(fc2));

  rec_t cur [3];
  logic fv  [3];
  always_comb begin
    cur[0] = {h0, s0, v0, w0, fc0, lk0};
    cur[1] = {h1, s1, v1, w1, fc1, lk1};
    cur[2] = {4'h0, h2, 4'h0, s2, 4'h0, v2, 4'h0, w2, 4'h0, fc2, lk2};
    fv[0]  = fv0;
    fv[1]  = fv1;
    fv[2]  = fv2;
  end

  int   pcnt [3] = '{0, 0, 0};
  rec_t plast [3];
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (fv[k]) begin
        pcnt[k]  <= pcnt[k] + 1;
        plast[k] <= cur[k];
      end
    end
  end

  int total = 0;
  int bad = 0;
  int snap [3];

  // Frame-level model: index 0 serves both 16-bit instances, index 1 the 12-bit one.
  int lh, lhw, lv, lvw;
  bit armed [2], fresh [2], mpulse [2];
  int run [2], mlk [2], mfc [2], mh [2], mhw [2], mv [2], mvw [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      armed[m] = 0; fresh[m] = 1; run[m] = 0; mlk[m] = 0; mfc[m] = 0;
      mh[m] = 0; mhw[m] = 0; mv[m] = 0; mvw[m] = 0; mpulse[m] = 0;
    end
  endtask

  // Start of a frame: the previous complete frame (lh..lvw) is reported, if armed.
  task automatic model_boundary(input int m);
    bit same, was_locked;
    mpulse[m] = 0;
    if (!armed[m]) begin
      armed[m] = 1;
      fresh[m] = 1;
    end else begin
      same       = (lh == mh[m]) && (lhw == mhw[m]) && (lv == mv[m]) && (lvw == mvw[m]);
      was_locked = (mlk[m] != 0);
      run[m]     = (fresh[m] || !same) ? 1 : run[m] + 1;
      fresh[m]   = 0;
      mlk[m]     = (run[m] >= LOCK) ? 1 : 0;
      if (was_locked && same) mfc[m] = (mfc[m] + 1) % ((m == 1) ? 4096 : 65536);
      mh[m] = lh; mhw[m] = lhw; mv[m] = lv; mvw[m] = lvw;
      mpulse[m] = 1;
    end
  endtask

  task automatic drive_frame(input int ht, input int hw, input int vt, input int vw);
    for (int l = 0; l < vt; l++) begin
      for (int p = 0; p < ht; p++) begin
        @(negedge clk);
        hs_pin = (p < hw) ? 1'b0 : 1'b1;
        vs_pin = (l < vw) ? 1'b0 : 1'b1;
      end
    end
  endtask

  task automatic check_pulses(input string tag);
    for (int k = 0; k < 3; k++) begin
      int m;
      m = (k == 2) ? 1 : 0;
      chk($sformatf("%s_npulse%0d", tag, k), pcnt[k] - snap[k], mpulse[m]);
      if (mpulse[m]) begin
        chk($sformatf("%s_ph%0d", tag, k),  plast[k].h,  mh[m]);
        chk($sformatf("%s_phw%0d", tag, k), plast[k].hw, mhw[m]);
        chk($sformatf("%s_pv%0d", tag, k),  plast[k].v,  mv[m]);
        chk($sformatf("%s_pvw%0d", tag, k), plast[k].vw, mvw[m]);
        chk($sformatf("%s_plk%0d", tag, k), plast[k].lk, mlk[m]);
        chk($sformatf("%s_pfc%0d", tag, k), plast[k].fc, mfc[m]);
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      int m;
      m = (k == 2) ? 1 : 0;
      chk($sformatf("%s_h%0d", tag, k),  cur[k].h,  mh[m]);
      chk($sformatf("%s_hw%0d", tag, k), cur[k].hw, mhw[m]);
      chk($sformatf("%s_v%0d", tag, k),  cur[k].v,  mv[m]);
      chk($sformatf("%s_vw%0d", tag, k), cur[k].vw, mvw[m]);
      chk($sformatf("%s_lk%0d", tag, k), cur[k].lk, mlk[m]);
      chk($sformatf("%s_fc%0d", tag, k), cur[k].fc, mfc[m]);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_fv%0d", tag, k), fv[k], 0);
      chk($sformatf("%s_all%0d", tag, k), cur[k], 0);
    end
  endtask

  task automatic step(input string tag, input int ht, input int hw, input int vt, input int vw);
    for (int k = 0; k < 3; k++) snap[k] = pcnt[k];
    model_boundary(0);
    model_boundary(1);
    drive_frame(ht, hw, vt, vw);
    check_pulses(tag);
    check_outputs(tag);
    lh = ht; lhw = hw; lv = vt; lvw = vw;
  endtask

  int bh, bw, bv, bvw;

  initial begin
    lh = 0; lhw = 0; lv = 0; lvw = 0;
    model_reset();
    bh  = $urandom_range(48, 24);
    bw  = $urandom_range(8, 2);
    bv  = $urandom_range(12, 6);
    bvw = $urandom_range(3, 1);

    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Acquire and lock on a steady timing
    repeat (4) step("lock", bh, bw, bv, bvw);

    // One longer-line frame breaks lock; two matching frames restore it
    step("bump", bh + 2, bw, bv, bvw);
    repeat (4) step("relock", bh, bw, bv, bvw);

    // hsync and vsync leading edges coincide on every frame start
    repeat (4) step("small", 20, 4, 10, 1);

    // Random mix of steady and disturbed frames
    repeat (8) begin
      if ($urandom_range(1, 0) == 1)
        step("rnd", bh, bw, bv, bvw);
      else
        step("rnd", $urandom_range(50, 16), $urandom_range(6, 1),
             $urandom_range(12, 4), $urandom_range(3, 1));
    end

    // Asynchronous reset in the middle of a locked frame
    repeat (3) step("prerst", bh, bw, bv, bvw);
    for (int k = 0; k < 3; k++) snap[k] = pcnt[k];
    model_boundary(0);
    model_boundary(1);
    fork
      drive_frame(bh, bw, bv, bvw);
      begin
        repeat ((bh * bv) / 2) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
      end
    join
    check_pulses("rstframe");
    model_reset();
    check_outputs("rstframe");
    lh = bh; lhw = bw; lv = bv; lvw = bvw;
    repeat (4) step("postrst", bh, bw, bv, bvw);

    // hsync stops: only the 12-bit instance reaches its saturation timeout
    repeat (4000 - bh) @(negedge clk);
    chk("to_still_locked", cur[2].lk, mlk[1]);
    repeat (150) @(negedge clk);
    mlk[1] = 0; run[1] = 0; armed[1] = 0; fresh[1] = 1;
    check_outputs("timeout");
    repeat (100) @(negedge clk);
    repeat (4) step("resume", bh, bw, bv, bvw);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
